// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, taken-branch flushes and
// data-memory wait holds with timeout, plus a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             R,
  input  logic [3:0]       ID_rn,
  input  logic [3:0]       ID_rm,
  input  logic             ID_uses_rn,
  input  logic             ID_uses_rm,
  input  logic             EX_load_instr,
  input  logic             EX_RF_enable,
  input  logic [3:0]       EX_rd,
  input  logic             ID_branch_taken,
  input  logic             MEM_mem_req,
  input  logic             mem_ready,
  output logic             PC_LE,
  output logic             IF_ID_LE,
  output logic             IF_ID_flush,
  output logic             CU_S,
  output logic             pipe_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [WC_W-1:0]   wait_cnt_r, wait_cnt_nxt_s;
  logic              mem_timeout_r, timeout_set_s;
  logic [CNT_W-1:0]  stall_cycles_r;
  logic              load_use_s, hold_s, eval_s;
  logic              pc_le_s, if_id_le_s, if_id_flush_s, cu_s_s, pipe_hold_s;

  assign load_use_s = EX_load_instr & EX_RF_enable &
                      ((ID_uses_rn & (ID_rn == EX_rd)) | (ID_uses_rm & (ID_rm == EX_rd)));

  // Next-state logic and Mealy output decode.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    timeout_set_s  = 1'b0;
    hold_s         = 1'b0;
    eval_s         = 1'b0;
    pc_le_s        = 1'b1;
    if_id_le_s     = 1'b1;
    if_id_flush_s  = 1'b0;
    cu_s_s         = 1'b0;
    pipe_hold_s    = 1'b0;

    case (state_r)
      RUN: begin
        if (MEM_mem_req && !mem_ready) begin
          hold_s         = 1'b1;
          state_nxt_s    = MEM_WAIT;
          wait_cnt_nxt_s = '0;
        end else begin
          eval_s = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          eval_s      = 1'b1;
          state_nxt_s = RUN;
        end else if (wait_cnt_r == WC_LAST) begin
          // access abandoned: release the pipe and latch the error
          timeout_set_s = 1'b1;
          eval_s        = 1'b1;
          state_nxt_s   = RUN;
        end else begin
          hold_s         = 1'b1;
          wait_cnt_nxt_s = wait_cnt_r + WC_W'(1);
        end
      end
      default: begin
        state_nxt_s    = RUN;
        wait_cnt_nxt_s = '0;
      end
    endcase

    if (hold_s) begin
      pc_le_s     = 1'b0;
      if_id_le_s  = 1'b0;
      pipe_hold_s = 1'b1;
    end else if (eval_s && ID_branch_taken) begin
      if_id_le_s    = 1'b0;
      if_id_flush_s = 1'b1;
    end else if (eval_s && load_use_s) begin
      pc_le_s    = 1'b0;
      if_id_le_s = 1'b0;
      cu_s_s     = 1'b1;
    end else begin
      pc_le_s = 1'b1;
    end

    // outputs are forced to a safe quiescent pattern while reset is held
    if (!R) begin
      pc_le_s       = 1'b0;
      if_id_le_s    = 1'b0;
      if_id_flush_s = 1'b1;
      cu_s_s        = 1'b1;
      pipe_hold_s   = 1'b0;
    end else begin
      pipe_hold_s = pipe_hold_s;
    end
  end

  // State, wait counter, sticky timeout flag and saturating stall counter.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_r        <= RUN;
      wait_cnt_r     <= '0;
      mem_timeout_r  <= 1'b0;
      stall_cycles_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      if (timeout_set_s) begin
        mem_timeout_r <= 1'b1;
      end
      if (!pc_le_s && (stall_cycles_r != {CNT_W{1'b1}})) begin
        stall_cycles_r <= stall_cycles_r + CNT_W'(1);
      end
    end
  end

  assign PC_LE        = pc_le_s;
  assign IF_ID_LE     = if_id_le_s;
  assign IF_ID_flush  = if_id_flush_s;
  assign CU_S         = cu_s_s;
  assign pipe_hold    = pipe_hold_s;
  assign mem_timeout  = mem_timeout_r;
  assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl (TIMEOUT=16, CNT_W=4).
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       R;
  logic [3:0] ID_rn, ID_rm, EX_rd;
  logic       ID_uses_rn, ID_uses_rm, EX_load_instr, EX_RF_enable;
  logic       ID_branch_taken, MEM_mem_req, mem_ready;
  logic       PC_LE, IF_ID_LE, IF_ID_flush, CU_S, pipe_hold, mem_timeout;
  logic [3:0] stall_cycles;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_stall = 4'd0;
  logic       exp_to = 1'b0;
  logic [4:0] exp_q[$];

  localparam logic [4:0] O_NORM = 5'b11000;
  localparam logic [4:0] O_HOLD = 5'b00001;
  localparam logic [4:0] O_LU   = 5'b00010;
  localparam logic [4:0] O_BR   = 5'b10100;
  localparam logic [4:0] O_RST  = 5'b00110;

  pipeline_hazard_ctrl #(.TIMEOUT(16), .CNT_W(4)) dut (
    .clk(clk), .R(R),
    .ID_rn(ID_rn), .ID_rm(ID_rm), .ID_uses_rn(ID_uses_rn), .ID_uses_rm(ID_uses_rm),
    .EX_load_instr(EX_load_instr), .EX_RF_enable(EX_RF_enable), .EX_rd(EX_rd),
    .ID_branch_taken(ID_branch_taken), .MEM_mem_req(MEM_mem_req), .mem_ready(mem_ready),
    .PC_LE(PC_LE), .IF_ID_LE(IF_ID_LE), .IF_ID_flush(IF_ID_flush), .CU_S(CU_S),
    .pipe_hold(pipe_hold), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {PC_LE, IF_ID_LE, IF_ID_flush, CU_S, pipe_hold};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    ID_rn = 4'd0; ID_rm = 4'd0; EX_rd = 4'd0;
    ID_uses_rn = 1'b0; ID_uses_rm = 1'b0; EX_load_instr = 1'b0; EX_RF_enable = 1'b0;
    ID_branch_taken = 1'b0; MEM_mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_lu(input logic [3:0] rd);
    EX_load_instr = 1'b1; EX_RF_enable = 1'b1; EX_rd = rd;
    ID_rn = rd; ID_uses_rn = 1'b1;
  endtask

  // Called at a falling edge with inputs already driven; checks one cycle.
  task automatic cyc(input string tag, input logic [4:0] exp_o, input logic to_set);
    exp_q.push_back(exp_o);
    #1;
    chk({tag, "_out"}, {3'b000, outs()}, {3'b000, exp_q.pop_front()});
    @(posedge clk);
    if (!exp_o[4] && exp_stall != 4'hF) exp_stall = exp_stall + 4'd1;
    if (to_set) exp_to = 1'b1;
    #1;
    chk({tag, "_cnt"}, {4'h0, stall_cycles}, {4'h0, exp_stall});
    chk({tag, "_to"}, {7'd0, mem_timeout}, {7'd0, exp_to});
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    R = 1'b0;
    exp_stall = 4'd0;
    exp_to = 1'b0;
    #1;
    chk({tag, "_out"}, {3'b000, outs()}, {3'b000, O_RST});
    chk({tag, "_cnt"}, {4'h0, stall_cycles}, 8'h00);
    chk({tag, "_to"}, {7'd0, mem_timeout}, 8'h00);
    @(negedge clk);
    R = 1'b1;
  endtask

  initial begin
    clr();
    R = 1'b0;
    #2;
    do_reset("reset");

    // load-use via Rn, then via Rm
    set_lu(4'd3);
    cyc("lu_rn", O_LU, 1'b0);
    clr();
    cyc("lu_after", O_NORM, 1'b0);
    EX_load_instr = 1'b1; EX_RF_enable = 1'b1; EX_rd = 4'd7;
    ID_rm = 4'd7; ID_uses_rm = 1'b1; ID_rn = 4'd7;
    cyc("lu_rm", O_LU, 1'b0);
    clr();
    // near-misses: operand unused, no RF write, not a load, different reg
    EX_load_instr = 1'b1; EX_RF_enable = 1'b1; EX_rd = 4'd5; ID_rn = 4'd5; ID_rm = 4'd5;
    cyc("nolu_unused", O_NORM, 1'b0);
    ID_uses_rn = 1'b1; EX_RF_enable = 1'b0;
    cyc("nolu_norf", O_NORM, 1'b0);
    EX_RF_enable = 1'b1; EX_load_instr = 1'b0;
    cyc("nolu_alu", O_NORM, 1'b0);
    EX_load_instr = 1'b1; ID_rn = 4'd6;
    cyc("nolu_diff", O_NORM, 1'b0);
    clr();

    // branch wins over load-use; branch alone
    set_lu(4'd15); ID_branch_taken = 1'b1;
    cyc("br_lu", O_BR, 1'b0);
    clr(); ID_branch_taken = 1'b1;
    cyc("br", O_BR, 1'b0);
    clr();

    // memory wait of 3 cycles
    MEM_mem_req = 1'b1;
    for (int i = 0; i < 3; i++) cyc("mw_hold", O_HOLD, 1'b0);
    mem_ready = 1'b1;
    cyc("mw_rel", O_NORM, 1'b0);
    clr();
    cyc("mw_after", O_NORM, 1'b0);
    MEM_mem_req = 1'b1; mem_ready = 1'b1;
    cyc("mw_same", O_NORM, 1'b0);
    clr();

    // memory wait overrides branch, re-evaluated on release
    MEM_mem_req = 1'b1; ID_branch_taken = 1'b1; set_lu(4'd2);
    cyc("mw_br_hold", O_HOLD, 1'b0);
    mem_ready = 1'b1;
    cyc("mw_br_rel", O_BR, 1'b0);
    clr();
    MEM_mem_req = 1'b1; set_lu(4'd9);
    cyc("mw_lu_hold", O_HOLD, 1'b0);
    mem_ready = 1'b1;
    cyc("mw_lu_rel", O_LU, 1'b0);
    clr();

    // timeout: 16 holds, release on the 17th with sticky flag
    MEM_mem_req = 1'b1;
    for (int i = 0; i < 16; i++) cyc("to_hold", O_HOLD, 1'b0);
    cyc("to_rel", O_NORM, 1'b1);
    clr();
    cyc("to_after", O_NORM, 1'b0);
    MEM_mem_req = 1'b1;
    cyc("to_k1_hold", O_HOLD, 1'b0);
    mem_ready = 1'b1;
    cyc("to_k1_rel", O_NORM, 1'b0);
    clr();

    // saturation from zero over 20 consecutive stalls
    do_reset("reset2");
    set_lu(4'd4);
    for (int i = 0; i < 20; i++) cyc("sat", O_LU, 1'b0);
    clr();
    cyc("sat_after", O_NORM, 1'b0);

    // reset asserted mid MEM_WAIT with stall_cycles=5
    do_reset("reset3");
    set_lu(4'd1);
    cyc("pre_lu", O_LU, 1'b0);
    clr(); MEM_mem_req = 1'b1;
    for (int i = 0; i < 4; i++) cyc("pre_hold", O_HOLD, 1'b0);
    chk("pre_cnt5", {4'h0, stall_cycles}, 8'h05);
    clr();
    do_reset("reset_mw");
    cyc("post_rst", O_NORM, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline sequencing controller for the five-stage ARM-subset core. Generates the PC load enable, IF/ID load/flush, CU_mux bubble select and a global pipeline hold from load-use hazards, taken branches and a variable-latency data-memory handshake. Sits beside the ID stage, observing ID, EX and MEM stage fields. Also counts stall cycles and flags data-memory timeouts.

## Interface
- TIMEOUT, 16: maximum MEM_WAIT duration before abandoning the access (≥2).
- CNT_W, 16: width of the stall-cycle counter.

- clk  in  1  core clock; all state updates on the rising edge.
- R  in  1  reset; asynchronous, active-low.
- ID_rn  in  4  Rn field of the instruction in ID.
- ID_rm  in  4  Rm field of the instruction in ID.
- ID_uses_rn  in  1  ID instruction reads Rn.
- ID_uses_rm  in  1  ID instruction reads Rm.
- EX_load_instr  in  1  instruction in EX is a load.
- EX_RF_enable  in  1  instruction in EX writes the register file.
- EX_rd  in  4  destination register of the instruction in EX.
- ID_branch_taken  in  1  B/BL in ID, condition passed.
- MEM_mem_req  in  1  MEM stage is accessing data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- PC_LE  out  1  PC load enable.
- IF_ID_LE  out  1  IF/ID load enable.
- IF_ID_flush  out  1  synchronous clear of IF/ID (drives its R).
- CU_S  out  1  CU_mux select; 1 inserts a NOP bubble into ID/EX.
- pipe_hold  out  1  freezes ID/EX, EX/MEM and MEM/WB.
- mem_timeout  out  1  sticky error flag.
- stall_cycles  out  CNT_W  saturating count of cycles with PC_LE=0.

## Operation
- States: RUN, MEM_WAIT. Registered: state, wait_cnt (ceil(log2 TIMEOUT) bits), mem_timeout, stall_cycles.
- load_use = EX_load_instr & EX_RF_enable & ((ID_uses_rn & ID_rn==EX_rd) | (ID_uses_rm & ID_rm==EX_rd)).
- Outputs are Mealy (state + current inputs). Default, "normal": PC_LE=1, IF_ID_LE=1, IF_ID_flush=0, CU_S=0, pipe_hold=0.
- Hold pattern: PC_LE=0, IF_ID_LE=0, CU_S=0, IF_ID_flush=0, pipe_hold=1.
- RUN rules, evaluated in priority order:
  - If MEM_mem_req & !mem_ready: apply the hold pattern; next state MEM_WAIT; wait_cnt<=0.
  - Else if ID_branch_taken: PC_LE=1 (the target is loaded), IF_ID_flush=1, IF_ID_LE=0, CU_S=0; stay in RUN.
  - Else if load_use: PC_LE=0, IF_ID_LE=0, CU_S=1 (one bubble); stay in RUN.
  - Else: normal.
- MEM_WAIT:
  - If mem_ready: evaluate the RUN branch/load-use/normal rules, ignoring the memory check; next state RUN.
  - Else if wait_cnt==TIMEOUT-1: set mem_timeout<=1; evaluate the RUN rules the same way; next state RUN. The access is abandoned.
  - Else: apply the hold pattern; wait_cnt<=wait_cnt+1.
- mem_timeout is cleared only by reset.
- stall_cycles increments on each edge where PC_LE==0 and R==1. It saturates at 2^CNT_W-1 and does not wrap.
- Register-equality checks are not gated on register 15; PC-relative hazards are resolved elsewhere.

## Timing
- Reset (R low) is asynchronous:
  - Registered state: state=RUN, wait_cnt=0, mem_timeout=0, stall_cycles=0.
  - Outputs forced while R is low: PC_LE=0, IF_ID_LE=0, IF_ID_flush=1, CU_S=1, pipe_hold=0.
- Reset in MEM_WAIT returns immediately to RUN. No pending access is remembered.
- A load-use stall lasts exactly 1 cycle, since the load advances to MEM. A back-to-back dependent pair costs 1 bubble.
- A taken branch costs 1 flushed fetch slot and has zero-cycle decision latency.
- Memory hold duration:
  - mem_ready arriving k cycles after MEM_mem_req first rises (k ≥ 1) gives exactly k hold cycles.
  - mem_ready in the same cycle as the request gives 0 hold cycles.
- Timeout: at most TIMEOUT hold cycles. Release and mem_timeout assertion occur on cycle TIMEOUT+1.
- Simultaneous events:
  - Memory wait overrides branch and load-use; those are re-evaluated on the release cycle.
  - Branch overrides load-use.

## Test plan
- Reset: R=0 mid-MEM_WAIT with stall_cycles=5 → immediately state RUN, stall_cycles=0, mem_timeout=0, IF_ID_flush=1, CU_S=1; after R=1, normal outputs.
- Load-use: EX_load_instr=1, EX_RF_enable=1, EX_rd=3; ID_rn=3, ID_uses_rn=1 → one cycle with PC_LE=0, IF_ID_LE=0, CU_S=1; next cycle normal; stall_cycles=1.
- Branch + load-use in the same cycle: ID_branch_taken=1 with load_use true → PC_LE=1, IF_ID_flush=1, CU_S=0; stall_cycles unchanged.
- Memory wait: MEM_mem_req=1, mem_ready low for 3 cycles, then high → pipe_hold=1 for exactly 3 cycles, release on cycle 4, stall_cycles=3, mem_timeout=0.
- Timeout: TIMEOUT=16, mem_ready held low → 16 hold cycles; cycle 17 releases with mem_timeout=1 sticky; a later normal access leaves it at 1.
- Saturation: CNT_W=4, 20 consecutive stall cycles → stall_cycles holds at 15.
